// File: rtl/uart_pkg.sv
// ---------------------------------------------------------------------------
// uart_pkg
// Purpose : definitions shared by the UART receiver and transmitter.
//           This package holds the data width, the receive FSM state type and
//           the parity helper.
// Ports   : none (package)
// ---------------------------------------------------------------------------
package uart_pkg;

    localparam int UART_DATA_W = 8;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } rx_state_t;

    // Value the parity bit must carry for the given data byte.
    // Even parity: the data's XOR. Odd parity: the inverse of it.
    function automatic logic parity_expected(input logic [UART_DATA_W-1:0] data,
                                             input logic odd);
        return odd ? ~(^data) : (^data);
    endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// ---------------------------------------------------------------------------
// uart_rx_fifo
// Purpose : synchronous first-word-fall-through FIFO for received bytes.
//           The head entry appears on dout while the FIFO is not empty.
// Ports   : clock       system clock (posedge)
//           reset       synchronous, active-low
//           push / din  write din at the tail (ignored when full unless a
//                       pop happens in the same cycle)
//           pop         advance the head (ignored when empty)
//           dout        head entry, forced to 0 while empty
//           empty/full  occupancy flags
//           count       entries currently held (0..DEPTH)
// ---------------------------------------------------------------------------
module uart_rx_fifo #(
    parameter  int WIDTH = 8,
    parameter  int DEPTH = 8,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             empty,
    output logic             full,
    output logic [AW:0]      count
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic             do_push;
    logic             do_pop;

    // Pointers are only AW bits wide, so they wrap modulo DEPTH by
    // themselves. The separate count is what tells full apart from empty.
    // A pop frees a slot within the same cycle, so a push into a full FIFO
    // still succeeds when a pop accompanies it.
    always_comb begin
        empty    = (count_q == '0);
        full     = (count_q == (AW+1)'(DEPTH));
        do_pop   = pop && !empty;
        do_push  = push && (!full || do_pop);
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + (AW+1)'(1);
            2'b01:   count_d = count_q - (AW+1)'(1);
            default: count_d = count_q;
        endcase
        dout  = empty ? '0 : mem_q[rd_ptr_q];
        count = count_q;
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset. Reads are masked by the empty flag.
    always_ff @(posedge clock) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= din;
        end
    end

endmodule

// File: rtl/uart_receiver.sv
// ---------------------------------------------------------------------------
// uart_receiver
// Purpose : 8-bit UART receiver (8N1 / 8E1 / 8O1) with a programmable bit
//           period. Received bytes go into a FWFT FIFO, and the module keeps
//           sticky framing, parity and overrun flags.
// Ports   : clock       system clock (posedge)
//           reset       synchronous, active-low
//           rx_bit      asynchronous serial input, idles high
//           baud_div    clocks per bit minus 1 (>= 3), latched at start edge
//           parity_en   a parity bit follows D7
//           parity_odd  1 = odd parity, 0 = even
//           rd_en       pop the FIFO head
//           err_clr     clear all sticky error flags
//           rx_data     FIFO head byte (0 while empty)
//           rx_valid    FIFO not empty
//           fifo_count  entries held
//           frame_err   sticky: stop bit sampled low
//           parity_err  sticky: parity mismatch on a pushed byte
//           overrun     sticky: byte dropped because the FIFO was full
// ---------------------------------------------------------------------------
module uart_receiver
    import uart_pkg::*;
#(
    parameter  int FIFO_DEPTH = 8,
    parameter  int DIV_W      = 16,
    localparam int CW         = $clog2(FIFO_DEPTH) + 1
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   rx_bit,
    input  logic [DIV_W-1:0]       baud_div,
    input  logic                   parity_en,
    input  logic                   parity_odd,
    input  logic                   rd_en,
    input  logic                   err_clr,
    output logic [UART_DATA_W-1:0] rx_data,
    output logic                   rx_valid,
    output logic [CW-1:0]          fifo_count,
    output logic                   frame_err,
    output logic                   parity_err,
    output logic                   overrun
);

    logic                   sync1_q, sync2_q;
    logic                   rx_s;
    rx_state_t              state_q, state_d;
    logic [DIV_W-1:0]       div_q, div_d;
    logic [DIV_W-1:0]       bit_cnt_q, bit_cnt_d;
    logic [2:0]             bit_idx_q, bit_idx_d;
    logic [UART_DATA_W-1:0] shift_q, shift_d;
    logic                   par_bad_q, par_bad_d;
    logic                   armed_q, armed_d;
    logic                   frame_err_q, frame_err_d;
    logic                   parity_err_q, parity_err_d;
    logic                   overrun_q, overrun_d;
    logic                   bit_done;
    logic                   push;
    logic                   frame_ev, parity_ev, overrun_ev;
    logic                   fifo_empty, fifo_full;

    assign rx_s = sync2_q;

    // Two-flop synchronizer for the asynchronous line. It resets to the idle
    // level so that reset alone never looks like a start edge.
    always_ff @(posedge clock) begin
        if (!reset) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
        end else begin
            sync1_q <= rx_bit;
            sync2_q <= sync1_q;
        end
    end

    // Next-state logic. After the start bit is confirmed at mid-bit, the
    // counter restarts, so each later sample lands one full period later,
    // again at mid-bit. armed_q records that rx_s was high on the previous
    // IDLE cycle. This stops a held-low line (break) from re-triggering
    // frames endlessly. A good stop bit re-arms at once, which lets the next
    // start edge be caught in the second half of the stop bit.
    always_comb begin
        state_d    = state_q;
        div_d      = div_q;
        bit_cnt_d  = bit_cnt_q;
        bit_idx_d  = bit_idx_q;
        shift_d    = shift_q;
        par_bad_d  = par_bad_q;
        armed_d    = armed_q;
        push       = 1'b0;
        frame_ev   = 1'b0;
        parity_ev  = 1'b0;
        overrun_ev = 1'b0;
        bit_done   = (bit_cnt_q == div_q);

        unique case (state_q)
            IDLE: begin
                armed_d = rx_s;
                if (!rx_s && armed_q) begin
                    state_d   = START;
                    div_d     = baud_div;
                    bit_cnt_d = '0;
                    par_bad_d = 1'b0;
                end
            end
            START: begin
                if (bit_cnt_q == (div_q >> 1)) begin
                    if (rx_s) begin
                        state_d = IDLE;
                        armed_d = 1'b1;
                    end else begin
                        state_d   = DATA;
                        bit_cnt_d = '0;
                        bit_idx_d = '0;
                    end
                end else begin
                    bit_cnt_d = bit_cnt_q + DIV_W'(1);
                end
            end
            DATA: begin
                if (bit_done) begin
                    bit_cnt_d = '0;
                    shift_d   = {rx_s, shift_q[UART_DATA_W-1:1]};
                    bit_idx_d = bit_idx_q + 3'd1;
                    if (bit_idx_q == 3'd7) begin
                        state_d = parity_en ? PARITY : STOP;
                    end
                end else begin
                    bit_cnt_d = bit_cnt_q + DIV_W'(1);
                end
            end
            PARITY: begin
                if (bit_done) begin
                    bit_cnt_d = '0;
                    par_bad_d = (rx_s != parity_expected(shift_q, parity_odd));
                    state_d   = STOP;
                end else begin
                    bit_cnt_d = bit_cnt_q + DIV_W'(1);
                end
            end
            STOP: begin
                if (bit_done) begin
                    state_d = IDLE;
                    armed_d = rx_s;
                    if (!rx_s) begin
                        frame_ev = 1'b1;
                    end else if (!fifo_full || rd_en) begin
                        push      = 1'b1;
                        parity_ev = par_bad_q;
                    end else begin
                        overrun_ev = 1'b1;
                    end
                end else begin
                    bit_cnt_d = bit_cnt_q + DIV_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        frame_err_d  = (frame_err_q  && !err_clr) || frame_ev;
        parity_err_d = (parity_err_q && !err_clr) || parity_ev;
        overrun_d    = (overrun_q    && !err_clr) || overrun_ev;
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q      <= IDLE;
            div_q        <= '0;
            bit_cnt_q    <= '0;
            bit_idx_q    <= '0;
            shift_q      <= '0;
            par_bad_q    <= 1'b0;
            armed_q      <= 1'b0;
            frame_err_q  <= 1'b0;
            parity_err_q <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            div_q        <= div_d;
            bit_cnt_q    <= bit_cnt_d;
            bit_idx_q    <= bit_idx_d;
            shift_q      <= shift_d;
            par_bad_q    <= par_bad_d;
            armed_q      <= armed_d;
            frame_err_q  <= frame_err_d;
            parity_err_q <= parity_err_d;
            overrun_q    <= overrun_d;
        end
    end

    uart_rx_fifo #(
        .WIDTH (UART_DATA_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clock (clock),
        .reset (reset),
        .push  (push),
        .pop   (rd_en),
        .din   (shift_q),
        .dout  (rx_data),
        .empty (fifo_empty),
        .full  (fifo_full),
        .count (fifo_count)
    );

    assign rx_valid   = !fifo_empty;
    assign frame_err  = frame_err_q;
    assign parity_err = parity_err_q;
    assign overrun    = overrun_q;

endmodule

// File: tb/tb_uart_receiver.sv
// ---------------------------------------------------------------------------
// tb_uart_receiver
// Purpose : directed testbench for uart_receiver at baud_div=15 (16 clocks
//           per bit) with a 10 ns clock.
// ---------------------------------------------------------------------------
module tb_uart_receiver;

    logic        clock;
    logic        reset;
    logic        rx_bit;
    logic [15:0] baud_div;
    logic        parity_en;
    logic        parity_odd;
    logic        rd_en;
    logic        err_clr;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic [3:0]  fifo_count;
    logic        frame_err;
    logic        parity_err;
    logic        overrun;

    int checkCount = 0;
    int passCount  = 0;
    int failCount  = 0;

    uart_receiver #(
        .FIFO_DEPTH (8),
        .DIV_W      (16)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .rx_bit     (rx_bit),
        .baud_div   (baud_div),
        .parity_en  (parity_en),
        .parity_odd (parity_odd),
        .rd_en      (rd_en),
        .err_clr    (err_clr),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .fifo_count (fifo_count),
        .frame_err  (frame_err),
        .parity_err (parity_err),
        .overrun    (overrun)
    );

    // 10 ns system clock
    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Compare one observed value with its expected value and keep the tallies
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checkCount++;
        assert (observed === expected) passCount++;
        else begin
            failCount++;
            $error("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Hold one serial bit for a full 16-clock bit period, starting just after a posedge
    task automatic driveBit(input logic v);
        @(posedge clock);
        #1 rx_bit = v;
        repeat (15) @(posedge clock);
    endtask

    // Send one frame. The stop bit is driven by hand so that rd_en can be
    // pulsed on the push cycle or rx_valid can be checked around the sample
    // edge. The stop sample falls on the 11th posedge after the stop bit starts.
    task automatic applyStimulus(input logic [7:0] data, input logic hasPar,
                                 input logic parBit, input logic stopBit,
                                 input logic popAtStop, input logic checkLatency);
        driveBit(1'b0);
        for (int i = 0; i < 8; i++) driveBit(data[i]);
        if (hasPar) driveBit(parBit);
        @(posedge clock);
        #1 rx_bit = stopBit;
        for (int i = 0; i < 15; i++) begin
            @(posedge clock);
            if (popAtStop && i == 9)  #1 rd_en = 1'b1;
            if (popAtStop && i == 10) #1 rd_en = 1'b0;
            if (checkLatency && i == 9) begin
                @(negedge clock);
                checkOutput("valid before stop sample", 32'(rx_valid), 32'd0);
            end
            if (checkLatency && i == 10) begin
                @(negedge clock);
                checkOutput("valid after stop sample", 32'(rx_valid), 32'd1);
                checkOutput("data after stop sample", 32'(rx_data), 32'(data));
            end
        end
        rx_bit = 1'b1;
    endtask

    // Check the head byte, then pop it with a one-cycle rd_en pulse
    task automatic popCheck(input logic [7:0] expected);
        @(negedge clock);
        checkOutput("pop data", 32'(rx_data), 32'(expected));
        rd_en = 1'b1;
        @(negedge clock);
        rd_en = 1'b0;
    endtask

    // One-cycle err_clr pulse
    task automatic clearErrors();
        @(negedge clock);
        err_clr = 1'b1;
        @(negedge clock);
        err_clr = 1'b0;
    endtask

    // Directed sequence covering reset, normal frames, glitch rejection,
    // framing, parity, overrun and mid-frame reset
    initial begin
        reset      = 1'b0;
        rx_bit     = 1'b1;
        baud_div   = 16'd15;
        parity_en  = 1'b0;
        parity_odd = 1'b0;
        rd_en      = 1'b0;
        err_clr    = 1'b0;

        // Reset state
        repeat (3) @(posedge clock);
        @(negedge clock);
        checkOutput("reset rx_valid", 32'(rx_valid), 32'd0);
        checkOutput("reset fifo_count", 32'(fifo_count), 32'd0);
        checkOutput("reset rx_data", 32'(rx_data), 32'd0);
        checkOutput("reset frame_err", 32'(frame_err), 32'd0);
        checkOutput("reset parity_err", 32'(parity_err), 32'd0);
        checkOutput("reset overrun", 32'(overrun), 32'd0);
        reset = 1'b1;
        repeat (4) @(posedge clock);

        // 0xA5 8N1 with latency check, then pop
        $display("[TB] 0xA5 8N1");
        applyStimulus(8'hA5, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
        @(negedge clock);
        checkOutput("A5 count", 32'(fifo_count), 32'd1);
        popCheck(8'hA5);
        checkOutput("A5 count after pop", 32'(fifo_count), 32'd0);

        // 4-cycle glitch is rejected, then 0x3C is received
        $display("[TB] start glitch");
        @(posedge clock);
        #1 rx_bit = 1'b0;
        repeat (4) @(posedge clock);
        #1 rx_bit = 1'b1;
        repeat (30) @(posedge clock);
        @(negedge clock);
        checkOutput("glitch count", 32'(fifo_count), 32'd0);
        checkOutput("glitch frame_err", 32'(frame_err), 32'd0);
        checkOutput("glitch parity_err", 32'(parity_err), 32'd0);
        checkOutput("glitch overrun", 32'(overrun), 32'd0);
        applyStimulus(8'h3C, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        @(negedge clock);
        checkOutput("3C count", 32'(fifo_count), 32'd1);
        popCheck(8'h3C);

        // Stop bit low: byte discarded, frame_err set, cleared by err_clr
        $display("[TB] framing error");
        applyStimulus(8'h3C, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge clock);
        checkOutput("frame count", 32'(fifo_count), 32'd0);
        checkOutput("frame_err set", 32'(frame_err), 32'd1);
        clearErrors();
        checkOutput("frame_err cleared", 32'(frame_err), 32'd0);
        repeat (5) @(posedge clock);

        // Odd parity: 0x07 needs parity bit 0, so 1 is a mismatch
        $display("[TB] odd parity");
        @(negedge clock);
        parity_en  = 1'b1;
        parity_odd = 1'b1;
        applyStimulus(8'h07, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        @(negedge clock);
        checkOutput("bad parity count", 32'(fifo_count), 32'd1);
        checkOutput("bad parity flag", 32'(parity_err), 32'd1);
        popCheck(8'h07);
        clearErrors();
        applyStimulus(8'h07, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        @(negedge clock);
        checkOutput("good parity count", 32'(fifo_count), 32'd1);
        checkOutput("good parity flag", 32'(parity_err), 32'd0);
        popCheck(8'h07);
        parity_en  = 1'b0;
        parity_odd = 1'b0;

        // Nine back-to-back bytes with no pops: the ninth overruns
        $display("[TB] overrun");
        for (int b = 1; b <= 9; b++) applyStimulus(8'(b), 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        @(negedge clock);
        checkOutput("overrun count", 32'(fifo_count), 32'd8);
        checkOutput("overrun flag", 32'(overrun), 32'd1);
        checkOutput("overrun frame_err", 32'(frame_err), 32'd0);
        for (int b = 1; b <= 8; b++) popCheck(8'(b));
        checkOutput("overrun drained", 32'(fifo_count), 32'd0);
        clearErrors();
        checkOutput("overrun cleared", 32'(overrun), 32'd0);

        // Same again with a pop on the ninth push cycle: no overrun
        $display("[TB] push+pop when full");
        for (int b = 1; b <= 8; b++) applyStimulus(8'(b), 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        applyStimulus(8'h09, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        @(negedge clock);
        checkOutput("full push+pop count", 32'(fifo_count), 32'd8);
        checkOutput("full push+pop overrun", 32'(overrun), 32'd0);
        for (int b = 2; b <= 9; b++) popCheck(8'(b));
        checkOutput("full push+pop drained", 32'(fifo_count), 32'd0);

        // Reset in the middle of a frame discards the partial byte
        $display("[TB] mid-frame reset");
        @(posedge clock);
        #1 rx_bit = 1'b0;
        repeat (40) @(posedge clock);
        #1 rx_bit = 1'b1;
        reset = 1'b0;
        repeat (2) @(posedge clock);
        #1 reset = 1'b1;
        repeat (200) @(posedge clock);
        @(negedge clock);
        checkOutput("mid-frame reset count", 32'(fifo_count), 32'd0);
        checkOutput("mid-frame reset frame_err", 32'(frame_err), 32'd0);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
